valve_actuator_ctrl: RTL and testbench



---
 rtl/fsm_valve_pkg.sv | 23 ++
 rtl/valve_channel.sv | 96 +++++++++
 rtl/valve_actuator_ctrl.sv | 84 ++++++++
 tb/tb_valve_actuator_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_valve_pkg.sv
// Shared types and helpers for the valve actuator controller.
// Optional build macro VALVE_RUNTIME_CNT_EN is consumed by valve_actuator_ctrl.
package fsm_valve_pkg;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    ON        = 2'd1,
    OFF_DWELL = 2'd2,
    LOCK      = 2'd3
  } chstate_t;

  typedef enum logic {CERRADA = 1'b0, ABIERTA = 1'b1} valve_t;
  typedef enum logic {Normal  = 1'b0, Error   = 1'b1} alarm_t;

  localparam int NUM_CH    = 2;
  localparam int RUNTIME_W = 16;

  // Dwell counter must hold the larger of the two reload values.
  function automatic int cnt_width(input int min_on, input int min_off);
    return $clog2(((min_on > min_off) ? min_on : min_off) + 1);
  endfunction

endpackage

// File: rtl/valve_channel.sv
// One valve channel: OFF/ON/OFF_DWELL/LOCK state machine with a shared
// dwell down-counter. All outputs come straight from flops.
module valve_channel
  import fsm_valve_pkg::*;
#(
  parameter int MIN_ON  = 8,
  parameter int MIN_OFF = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic fault,
  input  logic ack,
  output logic valve,
  output logic busy,
  output logic locked
);

  localparam int CNT_W = cnt_width(MIN_ON, MIN_OFF);
  localparam logic [CNT_W-1:0] ON_LD  = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] OFF_LD = CNT_W'(MIN_OFF - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  chstate_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valve_q, busy_q, locked_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      OFF: begin
        if (fault) begin
          state_d = LOCK;
        end else if (req) begin
          state_d = ON;
          cnt_d   = ON_LD;
        end
      end
      ON: begin
        // Fault wins over the minimum-on dwell.
        if (fault) begin
          state_d = LOCK;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else if (!req) begin
          state_d = OFF_DWELL;
          cnt_d   = OFF_LD;
        end
      end
      OFF_DWELL: begin
        // Expiry always passes through OFF so the request is re-sampled there.
        if (fault) begin
          state_d = LOCK;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else begin
          state_d = OFF;
        end
      end
      LOCK: begin
        if (!fault && ack) begin
          state_d = OFF_DWELL;
          cnt_d   = OFF_LD;
        end
      end
      default: begin
        state_d = OFF;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= OFF;
      cnt_q    <= '0;
      valve_q  <= CERRADA;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valve_q  <= (state_d == ON) ? ABIERTA : CERRADA;
      busy_q   <= ((state_d == ON) && (cnt_d != '0)) || (state_d == OFF_DWELL);
      locked_q <= (state_d == LOCK);
    end
  end

  assign valve  = valve_q;
  assign busy   = busy_q;
  assign locked = locked_q;

endmodule

// File: rtl/valve_actuator_ctrl.sv
// Two-channel valve actuator: dwell-protected valve drive, alarm latches, lockout.
// Define VALVE_RUNTIME_CNT_EN to add per-channel open-time counters (open_cycles).
module valve_actuator_ctrl
  import fsm_valve_pkg::*;
#(
  parameter int MIN_ON  = 8,
  parameter int MIN_OFF = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  C,
  input  logic [1:0]  Pout,
  input  logic        ack,
  output logic [1:0]  valve,
  output logic [1:0]  alarm,
  output logic        lockout,
  output logic [1:0]  busy
`ifdef VALVE_RUNTIME_CNT_EN
  ,
  output logic [31:0] open_cycles
`endif
);

  logic       fault;
  logic [1:0] locked;
  logic [1:0] alarm_q, alarm_d;

  assign fault = |Pout;

  valve_channel #(
    .MIN_ON  (MIN_ON),
    .MIN_OFF (MIN_OFF)
  ) u_ch [NUM_CH-1:0] (
    .clk    (clk),
    .reset  (reset),
    .req    (C),
    .fault  (fault),
    .ack    (ack),
    .valve  (valve),
    .busy   (busy),
    .locked (locked)
  );

  // Channels enter and leave LOCK in lockstep; the OR just folds them.
  assign lockout = |locked;

  // Set beats clear, so an ack during an active error keeps the alarm.
  always_comb begin
    alarm_d = alarm_q;
    for (int j = 0; j < NUM_CH; j++) begin
      if (Pout[j])  alarm_d[j] = Error;
      else if (ack) alarm_d[j] = Normal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) alarm_q <= '0;
    else       alarm_q <= alarm_d;
  end

  assign alarm = alarm_q;

`ifdef VALVE_RUNTIME_CNT_EN
  logic [NUM_CH-1:0][RUNTIME_W-1:0] oc_q, oc_d;

  always_comb begin
    oc_d = oc_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ack && !lockout)
        oc_d[i] = '0;
      else if (valve[i] && (oc_q[i] != {RUNTIME_W{1'b1}}))
        oc_d[i] = oc_q[i] + RUNTIME_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) oc_q <= '0;
    else       oc_q <= oc_d;
  end

  assign open_cycles = oc_q;
`endif

endmodule

// File: tb/tb_valve_actuator_ctrl.sv
// Bench for valve_actuator_ctrl: directed vector table, corner sequences,
// and randomized traffic against a timer-based reference model.
module tb_valve_actuator_ctrl;

  localparam int MIN_ON  = 4;
  localparam int MIN_OFF = 3;

  logic        clk;
  logic        reset;
  logic [1:0]  C, Pout;
  logic        ack;
  logic [1:0]  valve, alarm, busy;
  logic        lockout;
`ifdef VALVE_RUNTIME_CNT_EN
  logic [31:0] open_cycles;
`endif

  valve_actuator_ctrl #(.MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF)) dut (
    .clk     (clk),
    .reset   (reset),
    .C       (C),
    .Pout    (Pout),
    .ack     (ack),
    .valve   (valve),
    .alarm   (alarm),
    .lockout (lockout),
    .busy    (busy)
`ifdef VALVE_RUNTIME_CNT_EN
    ,
    .open_cycles (open_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: how long a valve has been open, how many closed-dwell
  // cycles remain, and a lock flag per channel.
  bit       m_open [2];
  int       m_age  [2];
  int       m_dw   [2];
  bit       m_lock [2];
  bit [1:0] m_alarm;
  int       m_oc   [2];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit [1:0] c, input bit [1:0] p, input bit a);
    bit fault, lk;
    fault = |p;
    lk    = m_lock[0] | m_lock[1];
    for (int i = 0; i < 2; i++) begin
      if (r)                         m_oc[i] = 0;
      else if (a && !lk)             m_oc[i] = 0;
      else if (m_open[i] && m_oc[i] < 65535) m_oc[i]++;
    end
    if (r) begin
      m_alarm = 2'b00;
      for (int i = 0; i < 2; i++) begin
        m_open[i] = 0; m_age[i] = 0; m_dw[i] = 0; m_lock[i] = 0;
      end
      return;
    end
    for (int j = 0; j < 2; j++) begin
      if (p[j])   m_alarm[j] = 1'b1;
      else if (a) m_alarm[j] = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (m_lock[i]) begin
        if (!fault && a) begin
          m_lock[i] = 0;
          m_dw[i]   = MIN_OFF;
        end
      end else if (fault) begin
        m_lock[i] = 1; m_open[i] = 0; m_dw[i] = 0; m_age[i] = 0;
      end else if (m_open[i]) begin
        if (m_age[i] < MIN_ON) m_age[i]++;
        else if (!c[i]) begin
          m_open[i] = 0; m_age[i] = 0; m_dw[i] = MIN_OFF;
        end
      end else if (m_dw[i] > 0) begin
        m_dw[i]--;
      end else if (c[i]) begin
        m_open[i] = 1; m_age[i] = 1;
      end
    end
  endtask

  function automatic logic [6:0] model_out();
    logic [1:0] v, b;
    for (int i = 0; i < 2; i++) begin
      v[i] = m_open[i];
      b[i] = (m_open[i] && m_age[i] < MIN_ON) || (m_dw[i] > 0);
    end
    return {v, b, m_alarm, m_lock[0] | m_lock[1]};
  endfunction

  task automatic step(input bit r, input bit [1:0] c, input bit [1:0] p, input bit a);
    reset = r; C = c; Pout = p; ack = a;
    @(posedge clk);
    model_update(r, c, p, a);
    #1;
    chk("model", {valve, busy, alarm, lockout}, {25'd0, model_out()});
`ifdef VALVE_RUNTIME_CNT_EN
    chk("model_oc", open_cycles, {m_oc[1][15:0], m_oc[0][15:0]});
`endif
  endtask

  typedef struct {
    bit       r;
    bit [1:0] c, p;
    bit       a;
    bit [1:0] v, b, al;
    bit       lk;
  } vec_t;

  function automatic vec_t mk(bit r, bit [1:0] c, bit [1:0] p, bit a,
                              bit [1:0] v, bit [1:0] b, bit [1:0] al, bit lk);
    vec_t t;
    t.r = r; t.c = c; t.p = p; t.a = a; t.v = v; t.b = b; t.al = al; t.lk = lk;
    return t;
  endfunction

  vec_t tbl [28];

  initial begin
    reset = 1'b1; C = 2'b00; Pout = 2'b00; ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_open[i] = 0; m_age[i] = 0; m_dw[i] = 0; m_lock[i] = 0; m_oc[i] = 0;
    end
    m_alarm = 2'b00;

    //            r  C  P  a  valve busy alarm lk
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 1, 1, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 1, 1, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 1, 1, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 1, 0, 0, 0);
    tbl[5]  = mk(0, 1, 0, 0, 1, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 1, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 1, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 1, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 1, 0, 0, 1, 1, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 1, 1, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 1, 1, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 1, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 1, 0, 0);
    tbl[15] = mk(0, 1, 0, 0, 0, 1, 0, 0);
    tbl[16] = mk(0, 1, 0, 0, 0, 1, 0, 0);
    tbl[17] = mk(0, 1, 0, 0, 0, 0, 0, 0);
    tbl[18] = mk(0, 1, 0, 0, 1, 1, 0, 0);
    tbl[19] = mk(0, 3, 0, 0, 3, 3, 0, 0);
    tbl[20] = mk(0, 3, 0, 0, 3, 3, 0, 0);
    tbl[21] = mk(0, 3, 2, 0, 0, 0, 2, 1);
    tbl[22] = mk(0, 3, 0, 0, 0, 0, 2, 1);
    tbl[23] = mk(0, 3, 0, 1, 0, 3, 0, 0);
    tbl[24] = mk(0, 3, 0, 0, 0, 3, 0, 0);
    tbl[25] = mk(0, 3, 0, 0, 0, 3, 0, 0);
    tbl[26] = mk(0, 3, 0, 0, 0, 0, 0, 0);
    tbl[27] = mk(0, 3, 0, 0, 3, 3, 0, 0);

    for (int k = 0; k < 28; k++) begin
      step(tbl[k].r, tbl[k].c, tbl[k].p, tbl[k].a);
      chk($sformatf("vec%0d", k), {valve, busy, alarm, lockout},
          {25'd0, tbl[k].v, tbl[k].b, tbl[k].al, tbl[k].lk});
    end

    // Fault held: ack is ignored until Pout drops.
    step(0, 2'b11, 2'b01, 0);
    chk("held_lock", {valve, lockout, alarm}, {28'd0, 2'b00, 1'b1, 2'b01});
    step(0, 2'b11, 2'b01, 1);
    chk("ack_ignored", {valve, lockout, alarm}, {28'd0, 2'b00, 1'b1, 2'b01});
    step(0, 2'b11, 2'b00, 0);
    chk("alarm_sticky", {lockout, alarm}, {29'd0, 1'b1, 2'b01});
    step(0, 2'b11, 2'b00, 1);
    chk("ack_clears", {lockout, alarm, busy}, {27'd0, 1'b0, 2'b00, 2'b11});

    // Request and fault rise together from OFF: valve must never open.
    step(1, 2'b00, 2'b00, 0);
    step(0, 2'b01, 2'b01, 0);
    chk("sim_rise", {valve, lockout}, {29'd0, 2'b00, 1'b1});
    step(0, 2'b01, 2'b01, 0);
    chk("sim_hold", valve, 32'd0);

    // Reset in the middle of the on-dwell.
    step(1, 2'b00, 2'b00, 0);
    step(0, 2'b01, 2'b00, 0);
    step(0, 2'b01, 2'b00, 0);
    chk("pre_rst_on", {valve, busy}, {28'd0, 2'b01, 2'b01});
    step(1, 2'b01, 2'b00, 0);
    chk("mid_rst", {valve, busy, alarm, lockout}, 32'd0);
`ifdef VALVE_RUNTIME_CNT_EN
    chk("oc_rst", open_cycles, 32'd0);
`endif

    // Randomized traffic; faults and resets kept rare so dwells complete.
    for (int n = 0; n < 600; n++) begin
      bit       r, a;
      bit [1:0] c, p;
      r = ($urandom_range(0, 99) == 0);
      c = 2'($urandom);
      p = ($urandom_range(0, 11) == 0) ? 2'($urandom) : 2'b00;
      a = ($urandom_range(0, 5) == 0);
      step(r, c, p, a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
